// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a fractional half-bit tick generator, valid/read handoff and error flags.
// Build option: define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_core #(
    parameter int CLKFREQ = 1000000,
    parameter int BAUD    = 115200
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    output logic       valid,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    // Accumulator steps: the sign bit clears once per half bit period.
    localparam logic [28:0] STEP_IDLE = 29'(2 * BAUD);
    localparam logic [28:0] STEP_TICK = 29'(2 * BAUD - CLKFREQ);

    logic        rx_meta_q, rx_meta_d;
    logic        rxs_q, rxs_d;
    logic [2:0]  state_q, state_d;
    logic [28:0] acc_q, acc_d;
    logic [4:0]  h_q, h_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        tick;
    logic        sample;
    logic        deliver;
    logic        new_perr;

    assign tick   = ~acc_q[28];
    // Bit centres fall on the ticks that move h to an odd value.
    assign sample = tick & ~h_q[0];

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic parity_err_q, parity_err_d;

    assign new_perr   = perr_q;
    assign parity_err = parity_err_q;
`else
    assign new_perr   = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign valid     = valid_q;
    assign data      = data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Frame sequencing, tick generation and host handoff
    always_comb begin
        rx_meta_d   = rx;
        rxs_d       = rx_meta_q;
        state_d     = state_q;
        acc_d       = acc_q + (tick ? STEP_TICK : STEP_IDLE);
        h_d         = tick ? h_q + 5'd1 : h_q;
        shift_d     = shift_q;
        valid_d     = valid_q;
        data_d      = data_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    acc_d   = STEP_TICK;
                    h_d     = 5'd0;
                    state_d = START;
                end
            end
            START: begin
                if (tick && h_q == 5'd0)
                    state_d = rxs_q ? IDLE : DATA;
            end
            DATA: begin
                if (sample) begin
                    shift_d = {rxs_q, shift_q[7:1]};
`ifdef UART_RX_PARITY_EN
                    if (h_q == 5'd16) state_d = PARITY;
`else
                    if (h_q == 5'd16) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    perr_d  = ^{shift_q, rxs_q};
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    deliver = 1'b1;
                    state_d = rxs_q ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rd && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || rd) begin
                valid_d     = 1'b1;
                data_d      = shift_q;
                frame_err_d = ~rxs_q;
`ifdef UART_RX_PARITY_EN
                parity_err_d = new_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers; the synchronizer resets to the idle line level
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= IDLE;
            acc_q       <= '0;
            h_q         <= '0;
            shift_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            h_q         <= h_d;
            shift_q     <= shift_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed-vector bench for uart_rx_core at 16 clocks per bit.
module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
    localparam int PB = 16;
`else
    localparam int PB = 0;
`endif

    logic       clk_i = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    int         n_vec = 0;
    int         n_err = 0;

    uart_rx_core #(.CLKFREQ(16), .BAUD(1)) dut (
        .clk_i(clk_i),
        .reset(reset),
        .rx(rx),
        .rd(rd),
        .valid(valid),
        .data(data),
        .frame_err(frame_err),
        .overrun(overrun),
        .parity_err(parity_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives start, data and (if built in) parity bits; leaves the line at the stop level.
    // Returns 144+PB cycles after the start edge.
    task automatic start_frame(input logic [7:0] b, input logic stop_bit, input logic flip);
        rx = 1'b0;
        wc(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wc(16);
        end
        rx = ^b ^ flip;
        wc(PB);
        rx = stop_bit;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        wc(1);
        rd = 1'b0;
    endtask

    initial begin
        rx = 1'b1;
        rd = 1'b0;
        reset = 1'b1;
        wc(3);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_perr", parity_err, 0);
        reset = 1'b0;
        wc(5);

        start_frame(8'hA5, 1'b1, 1'b0);
        wc(10);
        check("a5_before", valid, 0);
        wc(1);
        check("a5_valid", valid, 1);
        check("a5_data", data, 8'hA5);
        check("a5_ferr", frame_err, 0);
        check("a5_ovr", overrun, 0);
        check("a5_perr", parity_err, 0);
        pulse_rd();
        check("a5_rd_valid", valid, 0);
        check("a5_rd_data", data, 8'hA5);
        wc(24);

        rx = 1'b0;
        wc(4);
        rx = 1'b1;
        wc(40);
        check("glitch_valid", valid, 0);
        start_frame(8'h3C, 1'b1, 1'b0);
        wc(11);
        check("3c_valid", valid, 1);
        check("3c_data", data, 8'h3C);
        pulse_rd();
        wc(24);

        start_frame(8'h55, 1'b0, 1'b0);
        wc(11);
        check("55_valid", valid, 1);
        check("55_data", data, 8'h55);
        check("55_ferr", frame_err, 1);
        pulse_rd();
        wc(44);
        rx = 1'b1;
        wc(130);
        check("break_valid", valid, 0);
        check("break_ovr", overrun, 0);
        start_frame(8'h0F, 1'b1, 1'b0);
        wc(11);
        check("0f_valid", valid, 1);
        check("0f_data", data, 8'h0F);
        check("0f_ferr", frame_err, 0);
        pulse_rd();
        wc(24);

        start_frame(8'h11, 1'b1, 1'b0);
        wc(16);
        start_frame(8'h22, 1'b1, 1'b0);
        wc(11);
        check("ovr_valid", valid, 1);
        check("ovr_data", data, 8'h11);
        check("ovr_flag", overrun, 1);
        pulse_rd();
        check("ovr_rd_valid", valid, 0);
        check("ovr_rd_flag", overrun, 0);
        wc(24);

        start_frame(8'h11, 1'b1, 1'b0);
        wc(16);
        start_frame(8'h22, 1'b1, 1'b0);
        wc(10);
        check("sim_pre_data", data, 8'h11);
        pulse_rd();
        check("sim_valid", valid, 1);
        check("sim_data", data, 8'h22);
        check("sim_ovr", overrun, 0);
        wc(24);

        rx = 1'b0;
        wc(16);
        rx = 1'b1;
        wc(40);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        wc(2);
        reset = 1'b0;
        wc(200);
        check("post_rst_valid", valid, 0);

`ifdef UART_RX_PARITY_EN
        start_frame(8'h03, 1'b1, 1'b1);
        wc(11);
        check("par_valid", valid, 1);
        check("par_data", data, 8'h03);
        check("par_err", parity_err, 1);
        pulse_rd();
        wc(24);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1 UART receiver; the serial-in counterpart of the design's fractional baud generator and UART transmit path.
- Contains its own fractional-accumulator half-bit tick generator, re-phased on every start edge.
- Delivers one byte at a time through a valid/read handshake to the host bus.
- Reports framing and overrun errors.

Parameters:
- CLKFREQ, 1000000, clk_i frequency in Hz; must be < 2^27 and >= 4*BAUD.
- BAUD, 115200, line bit rate in bit/s.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rd  input  1  host consumes the byte on a cycle where valid=1.
- valid  output  1  data holds an unread byte.
- data  output  8  received byte, LSB first on the line.
- frame_err  output  1  stop bit of the held byte sampled low.
- overrun  output  1  sticky; a byte was dropped while valid=1.
- parity_err  output  1  parity mismatch on the held byte; see Optional Feature.

Behaviour:
- Reset, asserted asynchronously: valid=0, data=0, frame_err=0, overrun=0, parity_err=0, state=IDLE, accumulator=0, both synchronizer flops=1.
- Synchronizer: rx passes through two flops; rxs is the second flop. All decisions use rxs.
- Tick generator: 29-bit two's-complement accumulator d.
  - tick = ~d[28].
  - Each cycle, d += 2*BAUD - CLKFREQ if tick, else d += 2*BAUD.
  - Restart loads d = 2*BAUD - CLKFREQ, so the first tick occurs about half a bit later.
  - Ticks mark half-bit intervals. A half-bit counter h (5 bits) increments on each tick; restart clears h.
- States:
  - IDLE: on rxs=0, restart the tick generator and go to START. Cycle T is defined as this cycle.
  - START: on tick h=0→1 (start-bit centre), sample rxs. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample rxs on each odd-numbered half-tick (h=3,5,…,17) into a shift register, LSB first. After the 8th sample go to STOP (or PARITY when enabled).
  - STOP: sample at the next odd half-tick, which is the stop-bit centre. Deliver the byte (below). If the stop bit was 1, go to IDLE. If 0, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. No further bytes are generated while in BREAK.
- Delivery, in the cycle after the stop sample:
  - valid=0: load data and frame_err (=~stop bit) and parity_err, then set valid=1.
  - valid=1 and rd=1 in the same cycle: load the new byte and keep valid=1; overrun is not set.
  - valid=1 and rd=0: drop the new byte; data, frame_err and parity_err remain unchanged; set overrun=1.
- Read: rd=1 while valid=1 clears valid and overrun on the next edge. data is held until the next load. rd while valid=0 is ignored.
- Timing: with CLKFREQ=16 and BAUD=1, half-ticks occur at T+8k. Stop sample at T+152; valid rises at T+153. A pin falling edge at cycle P gives T=P+2.
- Back-to-back frames: a new start bit is accepted in the first IDLE cycle after STOP.
- Reset mid-frame: the frame is abandoned with no delivery; after release the block waits in IDLE.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; one sample at the next odd half-tick.
  - Even parity over the 8 data bits plus the parity bit must be 0; otherwise parity_err=1 for the delivered byte.
  - The stop sample shifts 2 half-ticks later, so valid rises at T+169 under the test parameters.
- Undefined: no PARITY state, and parity_err is tied to 0.

Test Plan:
- All tests use CLKFREQ=16, BAUD=1 (16 clk/bit).
- Send 0xA5 8N1, frame edge at P → valid=1 at P+155, data=0xA5, frame_err=0, overrun=0; pulse rd → valid=0 next cycle.
- Glitch: rx low for 4 cycles, then high → no valid; state returns to IDLE; a following 0x3C frame is received correctly.
- Send 0x55 with stop bit forced 0 and line held low for 40 more cycles → data=0x55, frame_err=1. No second byte appears; next frame 0x0F is received with frame_err=0.
- Overrun: send 0x11 then 0x22 back-to-back without rd → data=0x11, overrun=1. rd → valid=0, overrun=0.
- Simultaneous: assert rd exactly at the cycle the second byte 0x22 is delivered → data=0x22, valid=1, overrun=0.
- Assert reset at mid-DATA of a 0xFF frame → all outputs 0 immediately. Release with line high → no valid.
- With UART_RX_PARITY_EN, send 0x03 with parity bit 1 → parity_err=1.
